tc_dispatch_scheduler: RTL and testbench

- Replaces the fixed one-hot start/fetch_done rotation in front of the four-instance TensorCore cluster with a demand-driven scheduler.
- Accepts tile jobs over a valid/ready handshake and dispatches each job to an idle core, chosen round-robin.
- Sequences the core's shared fetch phase: start pulse, beat counting, fetch_done pulse.
- Collects write-back results in dispatch order and tags them with the job ID.

---
 rtl/tc_sched_pkg.sv | 19 +
 rtl/tc_rr_pick.sv | 27 ++
 rtl/tc_dispatch_scheduler.sv | 163 ++++++++++++++++
 tb/tb_tc_dispatch_scheduler.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_sched_pkg.sv
// Shared types, default sizing and helpers for the TensorCore dispatch scheduler.
package tc_sched_pkg;

  typedef enum logic [1:0] {
    D_IDLE,
    D_START,
    D_FETCH
  } disp_state_t;

  localparam int unsigned DEF_NUM_CORES   = 4;
  localparam int unsigned DEF_FETCH_BEATS = 4;
  localparam int unsigned DEF_WB_BEATS    = 4;
  localparam int unsigned DEF_ID_WIDTH    = 4;

  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/tc_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr+1, wrapping.
module tc_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/tc_dispatch_scheduler.sv
// Demand-driven job dispatcher for the TensorCore cluster: round-robin grant,
// serialised operand fetch, and in-order tagged write-back collection.
module tc_dispatch_scheduler
  import tc_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES   = DEF_NUM_CORES,
  parameter int unsigned FETCH_BEATS = DEF_FETCH_BEATS,
  parameter int unsigned WB_BEATS    = DEF_WB_BEATS,
  parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [ID_WIDTH-1:0]              job_id,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [NUM_CORES-1:0]             fetch_sel,
  output logic [NUM_CORES-1:0]             core_start,
  output logic [NUM_CORES-1:0]             core_fetch_done,
  input  logic [NUM_CORES-1:0]             core_idle,
  input  logic [NUM_CORES-1:0]             core_fetch,
  input  logic [NUM_CORES-1:0]             core_wb,
  output logic [NUM_CORES-1:0]             wb_sel,
  output logic                             out_valid,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic                             out_last,
  output logic [$clog2(NUM_CORES+1)-1:0]   outstanding,
  output logic                             wb_err
);

  localparam int unsigned IW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned FCW = $clog2(FETCH_BEATS + 1);
  localparam int unsigned WCW = $clog2(WB_BEATS + 1);
  localparam int unsigned OW  = $clog2(NUM_CORES + 1);

  function automatic logic [NUM_CORES-1:0] sel(input logic [IW-1:0] idx);
    return NUM_CORES'(onehot(32'(idx)));
  endfunction

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (32'(p) == NUM_CORES - 1) ? '0 : p + IW'(1);
  endfunction

  disp_state_t          state;
  logic [IW-1:0]        cur;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        grant;
  logic                 any_grant;
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] eligible;
  logic [FCW-1:0]       fcnt;
  logic [WCW-1:0]       wcnt;

  logic [ID_WIDTH-1:0]  id_table [NUM_CORES];
  logic [IW-1:0]        order_q  [NUM_CORES];
  logic [IW-1:0]        wr_ptr;
  logic [IW-1:0]        rd_ptr;
  logic [OW-1:0]        count;
  logic [IW-1:0]        head;

  logic accept;
  logic in_fire;
  logic empty;
  logic pop;
  logic wb_bad;

  // busy is the pre-update value, so a core freed by this cycle's last
  // write-back beat cannot be granted until the following cycle.
  assign eligible = core_idle & ~busy;

  tc_rr_pick #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any_grant)
  );

  assign job_ready = (state == D_IDLE) && any_grant;
  assign accept    = job_valid && job_ready;

  assign fetch_sel = (state == D_FETCH) ? sel(cur) : '0;
  assign in_ready  = (state == D_FETCH) && core_fetch[cur];
  assign in_fire   = in_valid && in_ready;

  assign empty       = (count == '0);
  assign head        = order_q[rd_ptr];
  assign out_valid   = !empty && core_wb[head];
  assign wb_sel      = out_valid ? sel(head) : '0;
  assign out_id      = id_table[head];
  assign out_last    = out_valid && (wcnt == WCW'(WB_BEATS - 1));
  assign pop         = out_last;
  assign outstanding = count;
  assign wb_bad      = empty ? (core_wb != '0) : ((core_wb & ~sel(head)) != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= D_IDLE;
      cur             <= '0;
      rr_ptr          <= '0;
      fcnt            <= '0;
      core_start      <= '0;
      core_fetch_done <= '0;
    end else begin
      core_start      <= '0;
      core_fetch_done <= '0;
      unique case (state)
        D_IDLE: begin
          if (accept) begin
            cur        <= grant;
            rr_ptr     <= grant;
            core_start <= sel(grant);
            state      <= D_START;
          end
        end
        D_START: begin
          if (core_fetch[cur]) state <= D_FETCH;
        end
        D_FETCH: begin
          if (in_fire) begin
            if (fcnt == FCW'(FETCH_BEATS - 1)) begin
              fcnt            <= '0;
              core_fetch_done <= sel(cur);
              state           <= D_IDLE;
            end else begin
              fcnt <= fcnt + FCW'(1);
            end
          end
        end
        default: state <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wcnt     <= '0;
      wb_err   <= 1'b0;
      order_q  <= '{default: '0};
      id_table <= '{default: '0};
    end else begin
      busy <= (busy & ~(pop ? sel(head) : '0)) | (accept ? sel(grant) : '0);
      if (accept) begin
        order_q[wr_ptr] <= grant;
        id_table[grant] <= job_id;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (accept && !pop)      count <= count + OW'(1);
      else if (pop && !accept) count <= count - OW'(1);
      if (out_valid) wcnt <= pop ? '0 : wcnt + WCW'(1);
      if (wb_bad) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tc_dispatch_scheduler.sv
// Bench for tc_dispatch_scheduler: directed job table, corner-case sequences,
// and a randomized run against a queue-based reference model.
module tb_tc_dispatch_scheduler;
  import tc_sched_pkg::*;

  localparam int NC  = 4;
  localparam int FB  = 4;
  localparam int WB  = 4;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           job_valid;
  logic           job_ready;
  logic [IDW-1:0] job_id;
  logic           in_valid;
  logic           in_ready;
  logic [NC-1:0]  fetch_sel;
  logic [NC-1:0]  core_start;
  logic [NC-1:0]  core_fetch_done;
  logic [NC-1:0]  core_idle;
  logic [NC-1:0]  core_fetch;
  logic [NC-1:0]  core_wb;
  logic [NC-1:0]  wb_sel;
  logic           out_valid;
  logic [IDW-1:0] out_id;
  logic           out_last;
  logic [2:0]     outstanding;
  logic           wb_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tc_dispatch_scheduler #(
    .NUM_CORES   (NC),
    .FETCH_BEATS (FB),
    .WB_BEATS    (WB),
    .ID_WIDTH    (IDW)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_id          (job_id),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .fetch_sel       (fetch_sel),
    .core_start      (core_start),
    .core_fetch_done (core_fetch_done),
    .core_idle       (core_idle),
    .core_fetch      (core_fetch),
    .core_wb         (core_wb),
    .wb_sel          (wb_sel),
    .out_valid       (out_valid),
    .out_id          (out_id),
    .out_last        (out_last),
    .outstanding     (outstanding),
    .wb_err          (wb_err)
  );

  typedef struct {
    logic [3:0] idle;
    logic [3:0] id;
    logic [3:0] start;
  } vec_t;

  typedef struct {
    int         core;
    logic [3:0] id;
  } ref_ent_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    job_valid  = 1'b0;
    job_id     = '0;
    in_valid   = 1'b0;
    core_idle  = '1;
    core_fetch = '0;
    core_wb    = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_defaults();
    #7;
    rstn = 1'b1;
    tick();
  endtask

  // Offers a job, expects grant 'exp', then runs the fetch phase to fetch_done.
  task automatic dispatch_fetch(input logic [3:0] id, input logic [3:0] exp, input bit stall);
    int beats;
    int c;
    job_valid = 1'b1;
    job_id    = id;
    #1;
    chk("job_ready", 32'(job_ready), 32'(1));
    tick();
    job_valid = 1'b0;
    #1;
    chk("core_start", 32'(core_start), 32'(exp));
    chk("fetch_sel_pre", 32'(fetch_sel), 32'(0));
    core_idle  = core_idle & ~exp;
    core_fetch = exp;
    tick();
    chk("core_start_1cyc", 32'(core_start), 32'(0));
    beats = 0;
    c     = 0;
    while (beats < FB && c < 40) begin
      in_valid   = stall ? (c % 2 == 0) : 1'b1;
      core_fetch = (stall && (c % 3 == 2)) ? 4'b0000 : exp;
      #1;
      chk("fetch_sel", 32'(fetch_sel), 32'(exp));
      chk("in_ready", 32'(in_ready), 32'(core_fetch != 4'b0000));
      chk("fetch_done_early", 32'(core_fetch_done), 32'(0));
      if (in_valid && core_fetch != 4'b0000) beats++;
      c++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("core_fetch_done", 32'(core_fetch_done), 32'(exp));
    chk("fetch_sel_post", 32'(fetch_sel), 32'(0));
    core_fetch = '0;
  endtask

  task automatic wb_phase(input logic [3:0] id, input logic [3:0] exp, input int outs);
    for (int k = 0; k < WB; k++) begin
      core_wb = exp;
      #1;
      chk("out_valid", 32'(out_valid), 32'(1));
      chk("wb_sel", 32'(wb_sel), 32'(exp));
      chk("out_id", 32'(out_id), 32'(id));
      chk("out_last", 32'(out_last), 32'(k == WB - 1));
      chk("outstanding_wb", 32'(outstanding), 32'(outs));
      tick();
    end
    core_wb   = '0;
    core_idle = core_idle | exp;
    #1;
    chk("outstanding_after", 32'(outstanding), 32'(outs - 1));
    chk("out_valid_after", 32'(out_valid), 32'(0));
  endtask

  task automatic run_job(input logic [3:0] idle, input logic [3:0] id, input logic [3:0] exp);
    core_idle = idle;
    if (exp == 4'b0000) begin
      job_valid = 1'b1;
      job_id    = id;
      #1;
      chk("job_ready_none", 32'(job_ready), 32'(0));
      tick();
      job_valid = 1'b0;
      #1;
      chk("core_start_none", 32'(core_start), 32'(0));
    end else begin
      dispatch_fetch(id, exp, 1'b0);
      wb_phase(id, exp, 1);
    end
    core_idle = '1;
  endtask

  // Reference model and core environment state for the randomized run
  bit       ref_busy [NC];
  int       ref_rr, owner, beats_r, wbcnt, pstart, pdone;
  bit       ref_open, ref_err;
  ref_ent_t ref_q [$];
  int       ph [NC];
  int       dly [NC];
  int       wbl [NC];
  int       env_q [$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1111, 4'h7, 4'b0100};
    tbl[1] = '{4'b1111, 4'h3, 4'b1000};
    tbl[2] = '{4'b1111, 4'h9, 4'b0001};
    tbl[3] = '{4'b0101, 4'hA, 4'b0100};
    tbl[4] = '{4'b0011, 4'hB, 4'b0001};
    tbl[5] = '{4'b1000, 4'hC, 4'b1000};
    tbl[6] = '{4'b1000, 4'hD, 4'b1000};
    tbl[7] = '{4'b0000, 4'hE, 4'b0000};
    tbl[8] = '{4'b0110, 4'hF, 4'b0010};

    // Reset state; in_valid outside the fetch phase must be ignored
    do_reset();
    in_valid = 1'b1;
    #1;
    chk("rst_core_start", 32'(core_start), 32'(0));
    chk("rst_fetch_done", 32'(core_fetch_done), 32'(0));
    chk("rst_fetch_sel", 32'(fetch_sel), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_outstanding", 32'(outstanding), 32'(0));
    chk("rst_wb_err", 32'(wb_err), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_wb_sel", 32'(wb_sel), 32'(0));
    chk("rst_job_ready", 32'(job_ready), 32'(1));
    in_valid = 1'b0;

    // Single job, id 5, all idle, rr_ptr 0 -> core 1
    run_job(4'b1111, 4'h5, 4'b0010);

    // Table of full jobs; grants follow the rotating pointer
    for (int i = 0; i < 9; i++) run_job(tbl[i].idle, tbl[i].id, tbl[i].start);

    // Four back-to-back jobs, then busy gating with all cores reporting idle
    do_reset();
    dispatch_fetch(4'h1, 4'b0010, 1'b0);
    dispatch_fetch(4'h2, 4'b0100, 1'b0);
    dispatch_fetch(4'h3, 4'b1000, 1'b0);
    dispatch_fetch(4'h4, 4'b0001, 1'b0);
    chk("b2b_outstanding", 32'(outstanding), 32'(4));
    core_idle = '1;
    job_valid = 1'b1;
    job_id    = 4'h9;
    #1;
    chk("b2b_job_ready_busy", 32'(job_ready), 32'(0));
    tick();
    job_valid = 1'b0;
    core_idle = '0;
    #1;
    chk("b2b_no_start", 32'(core_start), 32'(0));

    // Refill so core 3 is at the head with cores 0-2 busy
    wb_phase(4'h1, 4'b0010, 4);
    wb_phase(4'h2, 4'b0100, 3);
    dispatch_fetch(4'h5, 4'b0010, 1'b0);
    dispatch_fetch(4'h6, 4'b0100, 1'b0);
    core_idle = '0;
    for (int k = 0; k < WB; k++) begin
      core_wb = 4'b1000;
      if (k == WB - 1) begin
        core_idle = '1;
        job_valid = 1'b1;
        job_id    = 4'h7;
      end
      #1;
      chk("pop_out_id", 32'(out_id), 32'(3));
      chk("pop_out_last", 32'(out_last), 32'(k == WB - 1));
      if (k == WB - 1) begin
        chk("pop_job_ready", 32'(job_ready), 32'(0));
        chk("pop_outstanding4", 32'(outstanding), 32'(4));
      end
      tick();
    end
    core_wb = '0;
    #1;
    chk("pop_outstanding3", 32'(outstanding), 32'(3));
    chk("pop_no_start", 32'(core_start), 32'(0));
    chk("pop_job_ready_next", 32'(job_ready), 32'(1));
    tick();
    job_valid = 1'b0;
    #1;
    chk("pop_start_core3", 32'(core_start), 32'(4'b1000));
    chk("pop_outstanding4b", 32'(outstanding), 32'(4));

    // Fetch stall with toggling in_valid and a dropping core_fetch
    do_reset();
    dispatch_fetch(4'h8, 4'b0010, 1'b1);
    wb_phase(4'h8, 4'b0010, 1);

    // Out-of-order write-back, then write-back with an empty FIFO
    do_reset();
    dispatch_fetch(4'hA, 4'b0010, 1'b0);
    dispatch_fetch(4'hB, 4'b0100, 1'b0);
    core_wb = 4'b0100;
    #1;
    chk("ooo_out_valid", 32'(out_valid), 32'(0));
    chk("ooo_wb_sel", 32'(wb_sel), 32'(0));
    chk("ooo_wb_err_pre", 32'(wb_err), 32'(0));
    tick();
    core_wb = '0;
    #1;
    chk("ooo_wb_err", 32'(wb_err), 32'(1));
    wb_phase(4'hA, 4'b0010, 2);
    wb_phase(4'hB, 4'b0100, 1);
    chk("ooo_wb_err_sticky", 32'(wb_err), 32'(1));
    do_reset();
    #1;
    chk("empty_wb_err_pre", 32'(wb_err), 32'(0));
    core_wb = 4'b0001;
    #1;
    chk("empty_out_valid", 32'(out_valid), 32'(0));
    tick();
    core_wb = '0;
    #1;
    chk("empty_wb_err", 32'(wb_err), 32'(1));

    // Reset after two fetch beats abandons everything
    do_reset();
    job_valid = 1'b1;
    job_id    = 4'hC;
    #1;
    tick();
    job_valid  = 1'b0;
    core_fetch = 4'b0010;
    core_idle  = 4'b1101;
    tick();
    in_valid = 1'b1;
    repeat (2) tick();
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_fetch_sel", 32'(fetch_sel), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
    chk("mid_rst_outstanding", 32'(outstanding), 32'(0));
    chk("mid_rst_core_start", 32'(core_start), 32'(0));
    chk("mid_rst_fetch_done", 32'(core_fetch_done), 32'(0));
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    set_defaults();
    tick();
    rstn = 1'b1;
    run_job(4'b1111, 4'h3, 4'b0010);

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < NC; i++) begin
      ref_busy[i] = 1'b0;
      ph[i]       = 0;
      dly[i]      = 0;
      wbl[i]      = 0;
    end
    ref_rr = 0; owner = -1; beats_r = 0; wbcnt = 0; pstart = -1; pdone = -1;
    ref_open = 1'b0; ref_err = 1'b0;
    ref_q.delete();
    env_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int         h;
      int         eg;
      int         idx;
      bit         ea;
      bit         e_rdy;
      bit         e_ov;
      logic [3:0] e_start, e_done, e_fs, e_ws, other;
      job_valid = 1'($urandom_range(0, 1));
      job_id    = 4'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NC; i++) begin
        core_idle[i]  = (ph[i] == 0) && ($urandom_range(0, 3) != 0);
        core_fetch[i] = (ph[i] == 2);
        core_wb[i]    = (ph[i] == 4) && (env_q.size() > 0) && (env_q[0] == i) &&
                        ($urandom_range(0, 4) != 0);
      end
      #1;
      ea = 1'b0;
      eg = 0;
      for (int k = 1; k <= NC; k++) begin
        idx = (ref_rr + k) % NC;
        if (!ea && core_idle[idx] && !ref_busy[idx]) begin
          ea = 1'b1;
          eg = idx;
        end
      end
      e_rdy   = (owner < 0) && ea;
      e_start = (pstart >= 0) ? 4'(1 << pstart) : 4'b0000;
      e_done  = (pdone >= 0) ? 4'(1 << pdone) : 4'b0000;
      e_fs    = (owner >= 0 && ref_open) ? 4'(1 << owner) : 4'b0000;
      h       = (ref_q.size() > 0) ? ref_q[0].core : -1;
      e_ov    = (h >= 0) && core_wb[h];
      e_ws    = e_ov ? 4'(1 << h) : 4'b0000;
      other   = core_wb & ~((h >= 0) ? 4'(1 << h) : 4'b0000);
      chk("rnd_job_ready", 32'(job_ready), 32'(e_rdy));
      chk("rnd_core_start", 32'(core_start), 32'(e_start));
      chk("rnd_fetch_done", 32'(core_fetch_done), 32'(e_done));
      chk("rnd_fetch_sel", 32'(fetch_sel), 32'(e_fs));
      chk("rnd_in_ready", 32'(in_ready), 32'((owner >= 0) && ref_open && core_fetch[owner]));
      chk("rnd_out_valid", 32'(out_valid), 32'(e_ov));
      chk("rnd_wb_sel", 32'(wb_sel), 32'(e_ws));
      chk("rnd_out_last", 32'(out_last), 32'(e_ov && (wbcnt == WB - 1)));
      chk("rnd_outstanding", 32'(outstanding), 32'(ref_q.size()));
      chk("rnd_wb_err", 32'(wb_err), 32'(ref_err));
      if (e_ov) chk("rnd_out_id", 32'(out_id), 32'(ref_q[0].id));

      pstart = -1;
      pdone  = -1;
      if (other != 4'b0000) ref_err = 1'b1;
      if (e_ov) begin
        wbcnt++;
        if (wbcnt == WB) begin
          wbcnt       = 0;
          ref_busy[h] = 1'b0;
          void'(ref_q.pop_front());
        end
      end
      if (job_valid && e_rdy) begin
        owner        = eg;
        ref_open     = 1'b0;
        pstart       = eg;
        ref_busy[eg] = 1'b1;
        ref_rr       = eg;
        ref_q.push_back('{eg, job_id});
      end else if (owner >= 0 && !ref_open && core_fetch[owner]) begin
        ref_open = 1'b1;
      end else if (owner >= 0 && ref_open && in_valid && core_fetch[owner]) begin
        beats_r++;
        if (beats_r == FB) begin
          beats_r  = 0;
          pdone    = owner;
          owner    = -1;
          ref_open = 1'b0;
        end
      end

      for (int i = 0; i < NC; i++) begin
        case (ph[i])
          0: if (core_start[i]) begin
               ph[i]  = 1;
               dly[i] = $urandom_range(0, 2);
               env_q.push_back(i);
             end
          1: if (dly[i] == 0) ph[i] = 2; else dly[i]--;
          2: if (core_fetch_done[i]) begin
               ph[i]  = 3;
               dly[i] = $urandom_range(0, 3);
             end
          3: if (dly[i] == 0) begin
               ph[i]  = 4;
               wbl[i] = WB;
             end else dly[i]--;
          4: if (core_wb[i]) begin
               wbl[i]--;
               if (wbl[i] == 0) begin
                 ph[i] = 0;
                 void'(env_q.pop_front());
               end
             end
          default: ph[i] = 0;
        endcase
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
